ccg_resp_misr: RTL and testbench
================================

# ccg_resp_misr

Response compactor that sits directly downstream of a CCGRCG-class combinational benchmark netlist (15 inputs x0..x14, 12 outputs f1..f12). It accepts one 12-bit output vector per handshake and folds it into a 16-bit MISR signature. After a programmed number of vectors it compares the signature against a golden value and reports pass/fail. The same block also lets the dataset flow sign off resynthesised variants (e.g. RESYN2) against the original, without storing per-vector responses.

## Interface
Parameters:
- SIG_W, 16, signature width (fixed at 16 for the polynomial below)
- POLY, 16'h100B, feedback taps (x^16+x^12+x^3+x+1)
- SEED, 16'hFFFF, signature value loaded on start and on reset
- CNT_W, 16, vector counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  single-cycle pulse; begins a run
- num_vec  in  CNT_W  vectors in the run; sampled on accepted start
- golden  in  SIG_W  expected signature; sampled on accepted start
- resp_valid  in  1  resp_data is valid
- resp_ready  out  1  block can accept a vector
- resp_data  in  12  netlist outputs; bit0=f1 … bit11=f12
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  final signature == golden; meaningful only while done=1
- signature  out  SIG_W  current MISR value
- vec_cnt  out  CNT_W  vectors accepted in the current run
- alias_err  out  1  sticky alias violation (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE. state is registered; resp_ready = (state==RUN).
- IDLE:
  - start → load signature=SEED, vec_cnt=0, latch num_vec and golden.
  - If num_vec==0, go to DONE with pass=(SEED==golden). Otherwise go to RUN.
- RUN:
  - Accept occurs when resp_valid & resp_ready.
  - On accept: signature ← {sig[14:0],1'b0} ^ (sig[15] ? POLY : 0) ^ {4'b0, resp_data}; vec_cnt ← vec_cnt+1.
  - Accept with vec_cnt+1 == num_vec → DONE. pass is registered from the updated signature in the same edge.
  - start in RUN is ignored.
  - resp_valid low stalls the run indefinitely; state is unchanged.
- DONE:
  - done=1, and signature, pass and vec_cnt hold.
  - start → restarts exactly as from IDLE.
  - resp_data is ignored.
- All arithmetic is modulo 2^CNT_W / bitwise XOR. The counter never wraps, because num_vec ≤ 2^CNT_W−1.

## Timing
- Reset values: state=IDLE, resp_ready=0, busy=0, done=0, pass=0, signature=SEED, vec_cnt=0, alias_err=0.
- rst has priority over every other input and aborts any run mid-operation.
- Start accepted at edge t: busy=1 and resp_ready=1 from t+1. For num_vec=0, done=1 from t+1.
- A vector accepted at edge t appears in signature and vec_cnt from t+1.
- Last vector accepted at t: done=1, pass valid and resp_ready=0 from t+1. Accept-to-verdict latency is 1 cycle.
- Throughput is one vector per cycle with resp_valid held high.
- No combinational path from resp_valid to resp_ready.

## Configuration
- Macro: CCG_ALIAS_CHECK_EN.
- With the macro defined: on each accept, alias_err is set if resp_data bits {0..6,11} (f1..f7, f12) are not all equal, or bits {7..10} (f8..f11) are not all equal.
  - alias_err is sticky and is cleared by rst or an accepted start.
  - pass is forced to 0 if alias_err was set during the run.
- Without the macro: alias_err is tied to 0 and pass depends on the signature only.

## Test plan
- Reset: assert rst for 2 cycles mid-RUN → next cycle state IDLE, signature=16'hFFFF, done=0, resp_ready=0.
- Single vector: start with num_vec=1 and golden=16'hEFF5, send resp_data=12'h000 → done=1 one cycle after accept, signature=16'hEFF5, pass=1.
- Two vectors: num_vec=2, golden=16'hC01E, send 12'h000 then 12'hFFF → signature 16'hEFF5 then 16'hC01E, pass=1, vec_cnt=2. Repeat with golden=16'hC01F → pass=0.
- Stall and ignored start: num_vec=2 with resp_valid gapped for 5 cycles and start pulsed during RUN → same final signature 16'hC01E, vec_cnt unaffected by start.
- Zero length: num_vec=0, golden=16'hFFFF → done=1 one cycle after start, pass=1, resp_ready never asserted.
- Alias (macro defined): num_vec=1, golden=16'hEFF4, resp_data=12'h002 (f2≠f1) → signature=16'hEFF7, alias_err=1, pass=0. Without the macro: alias_err=0, pass=0 on signature mismatch only.

Source files
------------

// File: rtl/ccg_resp_misr.sv
// rtl/ccg_resp_misr.sv - 16-bit MISR compactor for CCGRCG netlist responses with golden compare.
// Optional alias checking on f1..f7,f12 / f8..f11 groups is enabled by CCG_ALIAS_CHECK_EN.
module ccg_resp_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h100B,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] golden,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [11:0]      resp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             alias_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             start_acc;
  logic [SIG_W-1:0] sig_step;
  logic [CNT_W-1:0] cnt_inc;
  logic             alias_d;

  assign accept    = resp_valid && (state_q == S_RUN);
  assign start_acc = start && (state_q != S_RUN);
  assign sig_step  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-12){1'b0}}, resp_data};
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef CCG_ALIAS_CHECK_EN
  // Each output group must toggle as a unit; any split means the netlist aliased.
  logic       alias_q;
  logic       alias_hit;
  logic [7:0] grp_a;
  logic [3:0] grp_b;

  assign grp_a     = {resp_data[11], resp_data[6:0]};
  assign grp_b     = resp_data[10:7];
  assign alias_hit = !((&grp_a) || !(|grp_a)) || !((&grp_b) || !(|grp_b));

  always_comb begin
    alias_d = alias_q;
    if (start_acc) begin
      alias_d = 1'b0;
    end else if (accept && alias_hit) begin
      alias_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alias_q <= 1'b0;
    end else begin
      alias_q <= alias_d;
    end
  end

  assign alias_err = alias_q;
`else
  assign alias_d   = 1'b0;
  assign alias_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    gold_d  = gold_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pass_d  = pass_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = S_DONE;
            pass_d  = (sig_step == gold_q) && !alias_d;
          end
        end
      end
      default: begin
        if (start_acc) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vec;
          gold_d  = golden;
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
          pass_d  = (num_vec == '0) && (SEED == golden);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      gold_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      gold_q  <= gold_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
    end
  end

  assign resp_ready = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign vec_cnt    = cnt_q;

endmodule

// File: tb/tb_ccg_resp_misr.sv
// tb/tb_ccg_resp_misr.sv - directed and randomized checks of ccg_resp_misr against an arithmetic MISR model.
module tb_ccg_resp_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] golden;
  logic        resp_valid;
  logic        resp_ready;
  logic [11:0] resp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_cnt;
  logic        alias_err;

  int tests  = 0;
  int failed = 0;

  int vecs[64];

  always #5 clk = ~clk;

  ccg_resp_misr dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
    .golden     (golden),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .vec_cnt    (vec_cnt),
    .alias_err  (alias_err)
  );

`ifdef CCG_ALIAS_CHECK_EN
  localparam bit ALIAS_EN = 1'b1;
`else
  localparam bit ALIAS_EN = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Polynomial division by x^16+x^12+x^3+x+1, then add the new response.
  function automatic int misr(input int s, input int d);
    int t;
    t = s * 2;
    if (t >= 65536) t = (t - 65536) ^ 'h100B;
    return t ^ d;
  endfunction

  function automatic bit aliased(input int d);
    int ones_a, ones_b;
    ones_a = 0;
    ones_b = 0;
    for (int b = 0; b < 12; b++) begin
      if ((d >> b) & 1) begin
        if (b >= 7 && b <= 10) ones_b++;
        else ones_a++;
      end
    end
    return !(ones_a == 0 || ones_a == 8) || !(ones_b == 0 || ones_b == 4);
  endfunction

  task automatic pulse_start(input int n, input int gold);
    start   = 1'b1;
    num_vec = n[15:0];
    golden  = gold[15:0];
    step();
    start   = 1'b0;
  endtask

  // Sends vecs[0..n-1] with random stalls; optionally pokes start while RUN.
  task automatic do_run(input string tag, input int n, input int gold,
                        input int max_gap, input bit poke);
    int  sig_m;
    bit  al_m;
    bit  pass_m;
    sig_m = 'hFFFF;
    al_m  = 1'b0;
    pulse_start(n, gold);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".ready"}, resp_ready, 1);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
        resp_valid = 1'b0;
        resp_data  = 12'($urandom);
        if (poke) begin
          start   = 1'b1;
          num_vec = 16'($urandom_range(3, 1));
          golden  = 16'($urandom);
        end
        step();
        start = 1'b0;
        chk({tag, ".stall_cnt"}, vec_cnt, i);
        chk({tag, ".stall_sig"}, signature, sig_m);
      end
      resp_valid = 1'b1;
      resp_data  = vecs[i][11:0];
      step();
      resp_valid = 1'b0;
      sig_m = misr(sig_m, vecs[i]);
      if (ALIAS_EN && aliased(vecs[i])) al_m = 1'b1;
      chk({tag, ".sig"}, signature, sig_m);
      chk({tag, ".cnt"}, vec_cnt, i + 1);
    end
    pass_m = (sig_m == gold) && !al_m;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".ready_off"}, resp_ready, 0);
    chk({tag, ".pass"}, pass, pass_m);
    chk({tag, ".alias"}, alias_err, al_m);
  endtask

  initial begin
    int sig_m;
    rst        = 1'b1;
    start      = 1'b0;
    num_vec    = '0;
    golden     = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset.sig", signature, 'hFFFF);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.ready", resp_ready, 0);
    chk("reset.pass", pass, 0);
    chk("reset.cnt", vec_cnt, 0);
    chk("reset.alias", alias_err, 0);

    // Single vector
    vecs[0] = 'h000;
    do_run("one", 1, 'hEFF5, 0, 1'b0);
    chk("one.sig_const", signature, 'hEFF5);
    chk("one.pass_const", pass, 1);

    // DONE holds while resp_data keeps moving
    resp_valid = 1'b1;
    resp_data  = 12'hABC;
    step();
    step();
    resp_valid = 1'b0;
    chk("hold.sig", signature, 'hEFF5);
    chk("hold.cnt", vec_cnt, 1);
    chk("hold.done", done, 1);

    // Two vectors, matching and mismatching golden
    vecs[0] = 'h000;
    vecs[1] = 'hFFF;
    do_run("two", 2, 'hC01E, 0, 1'b0);
    chk("two.sig_const", signature, 'hC01E);
    chk("two.pass_const", pass, 1);
    do_run("two_bad", 2, 'hC01F, 0, 1'b0);
    chk("two_bad.pass_const", pass, 0);

    // Stall gaps with start pulsed during RUN
    do_run("stall", 2, 'hC01E, 5, 1'b1);
    chk("stall.sig_const", signature, 'hC01E);
    chk("stall.cnt_const", vec_cnt, 2);

    // Zero-length run
    pulse_start(0, 'hFFFF);
    chk("zero.done", done, 1);
    chk("zero.pass", pass, 1);
    chk("zero.ready", resp_ready, 0);
    resp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zero.ready_hold", resp_ready, 0);
    end
    resp_valid = 1'b0;
    chk("zero.cnt", vec_cnt, 0);

    // Alias pattern: f2 differs from f1
    vecs[0] = 'h002;
    do_run("alias", 1, 'hEFF4, 0, 1'b0);
    chk("alias.sig_const", signature, 'hEFF7);
    chk("alias.pass_const", pass, 0);

    // A fresh start clears the sticky alias flag
    pulse_start(0, 'h1234);
    chk("alias_clr", alias_err, 0);
    chk("alias_clr.pass", pass, 0);

    // Randomized runs, half with an alias-free vector set and a matching golden
    for (int r = 0; r < 12; r++) begin
      int  n;
      bit  clean;
      int  gold;
      n     = $urandom_range(20, 1);
      clean = r[0];
      sig_m = 'hFFFF;
      for (int i = 0; i < n; i++) begin
        if (clean) begin
          int a, b;
          a = $urandom_range(1, 0);
          b = $urandom_range(1, 0);
          vecs[i] = (a ? 'h87F : 0) | (b ? 'h780 : 0);
        end else begin
          vecs[i] = $urandom_range(4095, 0);
        end
        sig_m = misr(sig_m, vecs[i]);
      end
      gold = ($urandom_range(1, 0) != 0) ? sig_m : (sig_m ^ (1 << $urandom_range(15, 0)));
      do_run($sformatf("rand%0d", r), n, gold, (r % 3), r[1]);
    end

    // Reset aborts a run in progress
    for (int i = 0; i < 4; i++) vecs[i] = $urandom_range(4095, 0);
    pulse_start(5, 'h0000);
    resp_valid = 1'b1;
    resp_data  = vecs[0][11:0];
    step();
    resp_data  = vecs[1][11:0];
    step();
    resp_valid = 1'b0;
    chk("abort.cnt_pre", vec_cnt, 2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("abort.sig", signature, 'hFFFF);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.ready", resp_ready, 0);
    chk("abort.cnt", vec_cnt, 0);
    step();
    chk("abort.idle", busy | done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
